// File: rtl/rv_pkg.sv
// Shared writeback definitions: default widths, the x0 index and the writeback record.
package rv_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  localparam logic [DEF_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] rd;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot. It loads on load, clears on drain, and
// accepts new data in the same cycle it drains.
module wb_slot
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] load_rd,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ready,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] data
);

  // Ready is derived only from slot state and the grant, never from valid.
  assign ready = !full || drain;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      rd   <= load_rd;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file write port: oldest slot
// drains first, x0 writes are suppressed, and pending destinations are exported.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit TIE_PRIO_B = 1'b0,
  parameter bit DROP_X0    = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       aValid,
  output logic                       aReady,
  input  logic [ADDR_WIDTH-1:0]      aRd,
  input  logic [DATA_WIDTH-1:0]      aData,
  input  logic                       bValid,
  output logic                       bReady,
  input  logic [ADDR_WIDTH-1:0]      bRd,
  input  logic [DATA_WIDTH-1:0]      bData,
  output logic                       regWrite,
  output logic [ADDR_WIDTH-1:0]      writeRegister,
  output logic [DATA_WIDTH-1:0]      writeData,
  output logic [(1<<ADDR_WIDTH)-1:0] pendingMask
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  // Handshake: a transfer happens on a port when valid && ready at posedge;
  // ready is high when the slot is empty or being granted this cycle.
  logic                  a_full, b_full;
  logic [ADDR_WIDTH-1:0] a_rd, b_rd;
  logic [DATA_WIDTH-1:0] a_data, b_data;
  logic                  a_load, b_load;
  logic                  grant_a, grant_b;
  logic                  a_older;
  logic                  granted;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  assign a_load = aValid && aReady;
  assign b_load = bValid && bReady;

  wb_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .load      (a_load),
    .drain     (grant_a),
    .load_rd   (aRd),
    .load_data (aData),
    .ready     (aReady),
    .full      (a_full),
    .rd        (a_rd),
    .data      (a_data)
  );

  wb_slot #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .load      (b_load),
    .drain     (grant_b),
    .load_rd   (bRd),
    .load_data (bData),
    .ready     (bReady),
    .full      (b_full),
    .rd        (b_rd),
    .data      (b_data)
  );

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      grant_a = a_older;
      grant_b = !a_older;
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  // The slot that stays full while the other loads becomes the older one.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_older <= 1'b0;
    end else if (a_load && b_load) begin
      a_older <= !TIE_PRIO_B;
    end else if (a_load && b_full && !grant_b) begin
      a_older <= 1'b0;
    end else if (b_load && a_full && !grant_a) begin
      a_older <= 1'b1;
    end
  end

  always_comb begin
    granted  = grant_a || grant_b;
    sel_rd   = '0;
    sel_data = '0;
    if (grant_a) begin
      sel_rd   = a_rd;
      sel_data = a_data;
    end else if (grant_b) begin
      sel_rd   = b_rd;
      sel_data = b_data;
    end
  end

  assign writeRegister = sel_rd;
  assign writeData     = sel_data;
  // Held entries still present during a reset cycle must not reach the register file.
  assign regWrite      = granted && !reset &&
                         !(DROP_X0 && (sel_rd == ADDR_WIDTH'(REG_ZERO)));

  always_comb begin
    pendingMask = '0;
    if (a_full) pendingMask[a_rd] = 1'b1;
    if (b_full) pendingMask[b_rd] = 1'b1;
    pendingMask[0] = 1'b0;
  end

  logic unused_num_regs;
  assign unused_num_regs = (NUM_REGS == 0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected writes are queued when driven
// and compared at each regWrite pulse.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = AW + DW;

  logic          clk;
  logic          reset;
  logic          aValid, bValid;
  logic          aReady, bReady;
  logic [AW-1:0] aRd, bRd;
  logic [DW-1:0] aData, bData;
  logic          regWrite;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;
  logic [31:0]   pendingMask;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic [DW-1:0] regs_model [32];

  regfile_wb_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIE_PRIO_B (1'b0),
    .DROP_X0    (1'b1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .aValid        (aValid),
    .aReady        (aReady),
    .aRd           (aRd),
    .aData         (aData),
    .bValid        (bValid),
    .bReady        (bReady),
    .bRd           (bRd),
    .bData         (bData),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .pendingMask   (pendingMask)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", writeRegister, writeData);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({writeRegister, writeData} !== mon_exp) begin
          failures++;
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   writeRegister, writeData, mon_exp[EW-1:DW], mon_exp[DW-1:0]);
        end
      end
      regs_model[writeRegister] = writeData;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aValid = 1'b0; aRd = '0; aData = '0;
    bValid = 1'b0; bRd = '0; bData = '0;
  endtask

  task automatic expect_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({regWrite, writeRegister, writeData} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b rd=%0d data=%h, required all zero", regWrite, writeRegister, writeData);
    end
    checks++;
    if (pendingMask !== 32'h0) begin
      failures++;
      $display("FAIL reset_mask: got %h, required 0", pendingMask);
    end
    checks++;
    if ({aReady, bReady} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready: got a=%b b=%b, required 1 1", aReady, bReady);
    end
    step();
  endtask

  task automatic test_single_write();
    aValid = 1'b1; aRd = 5'd5; aData = 32'h1234;
    exp_q.push_back({5'd5, 32'h1234});
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (pendingMask !== 32'h20) begin
      failures++;
      $display("FAIL single_mask_held: got %h, required 00000020", pendingMask);
    end
    checks++;
    if (regWrite !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: got regWrite=%b, required 1", regWrite);
    end
    step();
    @(negedge clk);
    checks++;
    if (pendingMask !== 32'h0 || regWrite !== 1'b0) begin
      failures++;
      $display("FAIL single_after: got mask=%h we=%b, required 0 0", pendingMask, regWrite);
    end
    step();
    expect_drained("single");
  endtask

  task automatic test_same_cycle();
    aValid = 1'b1; aRd = 5'd3; aData = 32'hA;
    bValid = 1'b1; bRd = 5'd3; bData = 32'hB;
    exp_q.push_back({5'd3, 32'hA});
    exp_q.push_back({5'd3, 32'hB});
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({aReady, bReady} !== 2'b10) begin
      failures++;
      $display("FAIL tie_ready: got a=%b b=%b, required 1 0", aReady, bReady);
    end
    checks++;
    if (pendingMask !== 32'h8) begin
      failures++;
      $display("FAIL tie_mask: got %h, required 00000008", pendingMask);
    end
    repeat (3) step();
    expect_drained("tie");
  endtask

  task automatic test_age_order();
    bValid = 1'b1; bRd = 5'd7; bData = 32'h77;
    exp_q.push_back({5'd7, 32'h77});
    step();
    idle_inputs();
    checks++;
    if (aReady !== 1'b1) begin
      failures++;
      $display("FAIL age_a_ready: got %b, required 1", aReady);
    end
    aValid = 1'b1; aRd = 5'd7; aData = 32'h11;
    exp_q.push_back({5'd7, 32'h11});
    step();
    idle_inputs();
    repeat (3) step();
    checks++;
    if (regs_model[7] !== 32'h11) begin
      failures++;
      $display("FAIL age_final_r7: got %h, required 00000011", regs_model[7]);
    end
    // B becomes older when A reloads behind it; A's second entry waits a cycle
    aValid = 1'b1; aRd = 5'd20; aData = 32'h201;
    bValid = 1'b1; bRd = 5'd21; bData = 32'h211;
    exp_q.push_back({5'd20, 32'h201});
    exp_q.push_back({5'd21, 32'h211});
    step();
    idle_inputs();
    aValid = 1'b1; aRd = 5'd22; aData = 32'h221;
    exp_q.push_back({5'd22, 32'h221});
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({aReady, bReady} !== 2'b01) begin
      failures++;
      $display("FAIL age_b_older_ready: got a=%b b=%b, required 0 1", aReady, bReady);
    end
    repeat (3) step();
    expect_drained("age");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        checks++;
        if (aReady !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready: cycle %0d got %b, required 1", k, aReady);
        end
        d = $urandom();
        aValid = 1'b1; aRd = AW'(k + 1); aData = d;
        exp_q.push_back({AW'(k + 1), d});
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (k >= 1) begin
        checks++;
        if (regWrite !== 1'b1) begin
          failures++;
          $display("FAIL b2b_pulse: cycle %0d got regWrite=%b, required 1", k, regWrite);
        end
      end
      step();
    end
    repeat (2) step();
    expect_drained("b2b");
  endtask

  task automatic test_x0();
    aValid = 1'b1; aRd = 5'd0; aData = 32'hFF;
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (regWrite !== 1'b0 || pendingMask !== 32'h0) begin
      failures++;
      $display("FAIL x0_drop: got we=%b mask=%h, required 0 0", regWrite, pendingMask);
    end
    step();
    @(negedge clk);
    checks++;
    if (pendingMask !== 32'h0 || aReady !== 1'b1) begin
      failures++;
      $display("FAIL x0_after: got mask=%h aReady=%b, required 0 1", pendingMask, aReady);
    end
    step();
    expect_drained("x0");
  endtask

  task automatic test_reset_mid();
    aValid = 1'b1; aRd = 5'd9;  aData = 32'h99;
    bValid = 1'b1; bRd = 5'd10; bData = 32'hAA;
    step();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (regWrite !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_write: got regWrite=%b, required 0", regWrite);
    end
    checks++;
    if (pendingMask !== 32'h600) begin
      failures++;
      $display("FAIL rstmid_both_full: got mask=%h, required 00000600", pendingMask);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({aReady, bReady} !== 2'b11 || pendingMask !== 32'h0 || regWrite !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after: got a=%b b=%b mask=%h we=%b, required 1 1 0 0",
               aReady, bReady, pendingMask, regWrite);
    end
    repeat (3) step();
    expect_drained("rstmid");
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs_model[r] = '0;
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_same_cycle();
    test_age_order();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
